// File: rtl/slave_to_master_mux_if.sv
// AHB response-path bundle between the address-phase bus, the slaves and the masters.
// The slave modport is the mux's view; the master modport drives it (masters/slaves/bench).
interface slave_to_master_mux_if #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 4,
   parameter int DATA_WIDTH  = 32
);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [DATA_WIDTH-1:0]                  Haddr;
   logic [1:0]                             Htrans;
   logic [MW-1:0]                          Hmaster;
   logic [NUM_SLAVES-1:0]                  Hsel;
   logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  Hrdata_S;
   logic [NUM_SLAVES-1:0]                  Hresp_S;
   logic [NUM_SLAVES-1:0]                  Hreadyout_S;
   logic [DATA_WIDTH-1:0]                  Hrdata;
   logic                                   Hresp;
   logic                                   Hready;
   logic [MW-1:0]                          Hmaster_d;

   modport slave (
      input  Haddr, Htrans, Hmaster, Hrdata_S, Hresp_S, Hreadyout_S,
      output Hsel, Hrdata, Hresp, Hready, Hmaster_d
   );

   modport master (
      output Haddr, Htrans, Hmaster, Hrdata_S, Hresp_S, Hreadyout_S,
      input  Hsel, Hrdata, Hresp, Hready, Hmaster_d
   );
endinterface

// File: rtl/slave_to_master_mux.sv
// AHB response mux: address decode to Hsel, data-phase slave routing back to the
// masters, and a built-in default slave giving the two-cycle ERROR for unmapped regions.
module slave_to_master_mux #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int REGION_BITS = 4
) (
   input  logic                   Hclk,
   input  logic                   Hreset,
   slave_to_master_mux_if.slave   bus
);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [REGION_BITS:0] NS_CMP = (REGION_BITS+1)'(NUM_SLAVES);

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

   logic [REGION_BITS-1:0] w_region;
   logic                   w_mapped;
   logic [NUM_SLAVES-1:0]  w_hsel;
   logic [DATA_WIDTH-1:0]  w_hrdata;
   logic                   w_hresp;
   logic                   w_hready;

   logic [REGION_BITS-1:0] r_sel_d;
   logic                   r_unmapped_d;
   logic                   r_active_d;
   logic [MW-1:0]          r_master_d;

   ds_state_t              r_ds_state;
   logic                   r_ds_hready;
   logic                   r_ds_hresp;

   // Hsel is deliberately not qualified by Htrans; slaves do that themselves.
   always_comb begin
      w_region = bus.Haddr[DATA_WIDTH-1 -: REGION_BITS];
      w_mapped = ({1'b0, w_region} < NS_CMP);
      w_hsel   = '0;
      for (int s = 0; s < NUM_SLAVES; s++)
         w_hsel[s] = w_mapped && (w_region == REGION_BITS'(s));
   end

   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = '0;
      if (r_active_d) begin
         if (r_unmapped_d) begin
            w_hready = r_ds_hready;
            w_hresp  = r_ds_hresp;
         end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
               if (r_sel_d == REGION_BITS'(s)) begin
                  w_hrdata = bus.Hrdata_S[s];
                  w_hresp  = bus.Hresp_S[s];
                  w_hready = bus.Hreadyout_S[s];
               end
            end
         end
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_sel_d      <= '0;
         r_unmapped_d <= 1'b0;
         r_active_d   <= 1'b0;
         r_master_d   <= '0;
      end else if (w_hready) begin
         r_sel_d      <= w_region;
         r_unmapped_d <= !w_mapped;
         r_active_d   <= bus.Htrans[1];
         r_master_d   <= bus.Hmaster;
      end
   end

   // Default slave; Hready is high in DS_ERR2 so its closing edge captures the next phase.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_ds_state  <= DS_IDLE;
         r_ds_hready <= 1'b1;
         r_ds_hresp  <= 1'b0;
      end else begin
         case (r_ds_state)
            DS_IDLE: begin
               if (w_hready && bus.Htrans[1] && !w_mapped) begin
                  r_ds_state  <= DS_ERR1;
                  r_ds_hready <= 1'b0;
                  r_ds_hresp  <= 1'b1;
               end
            end
            DS_ERR1: begin
               r_ds_state  <= DS_ERR2;
               r_ds_hready <= 1'b1;
               r_ds_hresp  <= 1'b1;
            end
            DS_ERR2: begin
               if (bus.Htrans[1] && !w_mapped) begin
                  r_ds_state  <= DS_ERR1;
                  r_ds_hready <= 1'b0;
                  r_ds_hresp  <= 1'b1;
               end else begin
                  r_ds_state  <= DS_IDLE;
                  r_ds_hready <= 1'b1;
                  r_ds_hresp  <= 1'b0;
               end
            end
            default: begin
               r_ds_state  <= DS_IDLE;
               r_ds_hready <= 1'b1;
               r_ds_hresp  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Hsel      = w_hsel;
   assign bus.Hrdata    = w_hrdata;
   assign bus.Hresp     = w_hresp;
   assign bus.Hready    = w_hready;
   assign bus.Hmaster_d = r_master_d;
endmodule
